// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, base coefficients and FSM states for the convolution scheduler
package conv_pkg;

  typedef logic [2:0][2:0][3:0] pixel_win_t;
  typedef logic [2:0][2:0][4:0] filter_t;
  typedef logic [9:0]           conv_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CALC,
    WAIT,
    OUT,
    NEXT,
    FIN
  } state_t;

  // Row 0 = [1,2,1], row 1 = [0,0,0], row 2 = [-1,-2,-1]; leftmost element is the highest index.
  localparam filter_t BASE_FILTER = {{5'h1f, 5'h1e, 5'h1f},
                                     {5'h00, 5'h00, 5'h00},
                                     {5'h01, 5'h02, 5'h01}};

  // A zero level would null the centre column, so it is lifted to 1; anything above 4 saturates.
  function automatic logic [2:0] eff_brightness(input logic [3:0] lvl);
    if (lvl == 4'd0) begin
      return 3'd1;
    end else if (lvl > 4'd4) begin
      return 3'd4;
    end else begin
      return lvl[2:0];
    end
  endfunction

endpackage

// File: rtl/filter_gen.sv
// rtl/filter_gen.sv - combinational coefficient set with brightness-scaled centre column
module filter_gen
  import conv_pkg::*;
(
  input  logic [3:0] brightness,
  output filter_t    filter
);

  logic signed [4:0] scale;

  // Start from the base set and scale only the centre column entries.
  always_comb begin
    scale  = {2'b00, eff_brightness(brightness)};
    filter = BASE_FILTER;
    for (int r = 0; r < 3; r++) begin
      filter[r][1] = 5'($signed(BASE_FILTER[r][1]) * scale);
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// rtl/conv_scheduler.sv - walks 3x3 windows in raster order and sequences the convolution engine
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_HEIGHT = 9,
  parameter int IMG_WIDTH  = 9,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] brightness,
  output logic [3:0] win_row,
  output logic [3:0] win_col,
  output logic       calc_enable,
  output filter_t    filter,
  input  logic       calc_done,
  input  conv_t      conv,
  output logic       result_valid,
  input  logic       result_ready,
  output conv_t      result_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    bright_q, bright_d;
  logic [TW-1:0] tmo_q, tmo_d;
  conv_t         data_q, data_d;
  logic          err_q, err_d;
  logic          last_col, last_row, tmo_hit;
  filter_t       gen_filter;

  assign last_col = (col_q == 4'(IMG_WIDTH - 3));
  assign last_row = (row_q == 4'(IMG_HEIGHT - 3));
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  // Next-state, window stepping, timeout counting and result capture.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    bright_d = bright_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bright_d = brightness;
          err_d    = 1'b0;
          row_d    = 4'd0;
          col_d    = 4'd0;
          state_d  = ADDR;
        end
      end
      ADDR: state_d = CALC;
      CALC: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion arriving in the last waiting cycle still beats the timeout.
        if (calc_done) begin
          data_d  = conv;
          state_d = OUT;
        end else if (tmo_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = OUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      OUT: begin
        if (result_ready) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (last_col && last_row) begin
          state_d = FIN;
        end else if (last_col) begin
          col_d   = 4'd0;
          row_d   = row_q + 4'd3;
          state_d = ADDR;
        end else begin
          col_d   = col_q + 4'd3;
          state_d = ADDR;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any window in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      bright_q <= 4'd1;
      tmo_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      bright_q <= bright_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  filter_gen u_filter_gen (
    .brightness (bright_q),
    .filter     (gen_filter)
  );

  // The latched level only changes in IDLE, so the set is constant for the whole image.
  assign filter       = (state_q != IDLE) ? gen_filter : '0;
  assign win_row      = row_q;
  assign win_col      = col_q;
  assign calc_enable  = (state_q == CALC);
  assign result_valid = (state_q == OUT);
  assign result_data  = data_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign err          = err_q;

endmodule

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameter IMG_HEIGHT, default 9: image rows in pixels; SHALL be a multiple of 3.
REQ-002 Parameter IMG_WIDTH, default 9: image columns in pixels; SHALL be a multiple of 3.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles spent waiting for calc_done.
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on rising edge.
REQ-005 Port n_rst, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: single-cycle request to process one full image.
REQ-007 Port brightness, input, 4: brightness level, sampled when start is accepted.
REQ-008 Port win_row / win_col, output, 4 each: top-left pixel address of the current 3x3 window, driven to the pixel buffer.
REQ-009 Port calc_enable, output, 1: one-cycle start pulse to the convolution engine.
REQ-010 Port filter, output, [2:0][2:0][4:0]: coefficient set driven to the convolution engine.
REQ-011 Port calc_done / conv, input, 1 / 10: engine completion flag and result.
REQ-012 Port result_valid / result_ready, output / input, 1 each: result handshake.
REQ-013 Port result_data, output, 10: captured conv value.
REQ-014 Port busy / done / err, output, 1 each: running; one-cycle end-of-image pulse; sticky timeout flag.

Function
REQ-015 States SHALL be IDLE, ADDR, CALC, WAIT, OUT, NEXT, and FIN.
REQ-016 IDLE: on start=1, latch brightness, clear err, set win_row=win_col=0, go to ADDR; start SHALL be ignored in every other state.
REQ-017 ADDR: hold the address for exactly one cycle to cover buffer read latency, then go to CALC.
REQ-018 CALC: calc_enable=1 for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT: when calc_done=1, capture conv into result_data and go to OUT.
REQ-020 WAIT timeout: after TIMEOUT cycles without calc_done, set result_data=0 and err=1, then go to OUT.
REQ-021 If calc_done and timeout occur in the same cycle, calc_done SHALL win.
REQ-022 OUT: hold result_valid=1 with result_data stable until result_ready=1; the transfer completes in that cycle, then go to NEXT.
REQ-023 NEXT, column step: win_col advances by 3 and the FSM returns to ADDR.
REQ-024 NEXT, row step: at the last column, win_col wraps to 0, win_row advances by 3, and the FSM returns to ADDR.
REQ-025 NEXT, last window: at row IMG_HEIGHT-3 and column IMG_WIDTH-3, go to FIN.
REQ-026 FIN: done=1 for one cycle, then go to IDLE.
REQ-027 Window order SHALL be raster order; the defaults give 9 windows.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Filter SHALL be the base coefficients [1,2,1 / 0,0,0 / -1,-2,-1] with both centre-column entries multiplied by the effective brightness b.
REQ-030 Effective brightness b: latched value 0 becomes 1; latched values above 4 clamp to 4.
REQ-031 Filter SHALL be held constant from start acceptance until FIN.

Reset
REQ-032 On n_rst=0, asynchronously enter IDLE and clear all counters.
REQ-033 During reset, every output SHALL be 0, including filter; latched brightness resets to 1.
REQ-034 Reset mid-image SHALL abandon the current window; no done pulse is issued.

Structure
REQ-035 Package conv_pkg SHALL hold pixel_win_t ([2:0][2:0][3:0]), filter_t ([2:0][2:0][4:0]), conv_t (10-bit), BASE_FILTER, and the state enum.
REQ-036 Filter construction (REQ-029, REQ-030) SHALL be a combinational sub-module, filter_gen.

Verification
REQ-037 Reset: assert n_rst=0 mid-cycle -> all outputs read 0 immediately.
REQ-038 Full image: brightness=2; engine stub returns conv=window index 3 cycles after calc_enable; result_ready tied to 1 -> 9 results 0..8 at (0,0),(0,3)..(6,6), then one done pulse, and err=0.
REQ-039 Filter: brightness=3 -> filter[0][1]=5'b00110, filter[2][1]=5'b11010; brightness=0 -> filter[0][1]=5'b00010; brightness=9 -> filter[0][1]=5'b01000.
REQ-040 Backpressure: result_ready=0 for 5 cycles -> result_valid and result_data stable, win_col unchanged, no calc_enable until the transfer completes.
REQ-041 Timeout: stub never raises calc_done on window 4 -> result_data=0 16 cycles after calc_enable, err=1, and the remaining windows still complete.
REQ-042 Robustness: start pulsed during WAIT -> ignored; n_rst pulsed during window 5 -> IDLE, busy=0, no done pulse.
